// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: state encoding and default geometry shared by the memory arbiter files.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ACCESS     = 2'd1,
        RD_CAPTURE = 2'd2
    } state_e;

    localparam int ADDR_W    = 5;
    localparam int DATA_W    = 16;
    localparam int MEM_DEPTH = 2 ** ADDR_W;

    // Width of a requester index; never zero so a one-requester build still has a pointer.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester-side bundle plus the memory strobes of the arbiter.
// Latency: n/a (wiring only).
// Backpressure: REQ held until GNT. Optional MEM_ARBITER_LOCK_EN adds the lock vector.
interface mem_arbiter_if import mem_arbiter_pkg::*; #(
    parameter int N_REQ = 2,
    parameter int AW    = ADDR_W,
    parameter int DW    = DATA_W
) ();
    logic [N_REQ-1:0]    req;
    logic [N_REQ-1:0]    we;
    logic [N_REQ*AW-1:0] addr;
    logic [N_REQ*DW-1:0] wdata;
    logic [N_REQ-1:0]    gnt;
    logic [N_REQ-1:0]    rvalid;
    logic [DW-1:0]       rdata;
    logic                mem_mrd;
    logic                mem_mwr;
    logic [AW-1:0]       mem_addr;
    logic [DW-1:0]       mem_wdata;
    logic [DW-1:0]       mem_rdata;
`ifdef MEM_ARBITER_LOCK_EN
    logic [N_REQ-1:0]    lock;
`endif

    // Environment view: requesters plus the memory model.
    modport master (
        output req, we, addr, wdata, mem_rdata,
`ifdef MEM_ARBITER_LOCK_EN
        output lock,
`endif
        input  gnt, rvalid, rdata, mem_mrd, mem_mwr, mem_addr, mem_wdata
    );

    // Arbiter view.
    modport slave (
        input  req, we, addr, wdata, mem_rdata,
`ifdef MEM_ARBITER_LOCK_EN
        input  lock,
`endif
        output gnt, rvalid, rdata, mem_mrd, mem_mwr, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter_rr_arbiter.sv
// rr_arbiter: one-hot grant to the first asserted request at or after the pointer, wrapping.
// Latency: combinational.
// Backpressure: none; the caller decides when the grant is taken.
module rr_arbiter import mem_arbiter_pkg::*; #(
    parameter int N_REQ = 2,
    parameter int PW    = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [PW-1:0]    ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [PW-1:0]    idx_o
);
    logic [PW-1:0] cand;
    logic          found;

    // Scan N_REQ slots starting at the pointer; the first hit masks all later ones.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = PW'((int'(ptr_i) + k) % N_REQ);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of one single-port memory between N_REQ requesters.
// Latency: write req->GNT 1 cycle (1 per 2 cycles); read req->RVALID 3 cycles (1 per 3).
// Backpressure: REQ held until GNT; REQ ignored while an access is in flight. MEM_ARBITER_LOCK_EN adds LOCK.
module mem_arbiter import mem_arbiter_pkg::*; #(
    parameter int N_REQ = 2,
    parameter int AW    = ADDR_W,
    parameter int DW    = DATA_W
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_arbiter_if.slave bus
);
    localparam int PW = idx_width(N_REQ);

    state_e           state_q, state_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [PW-1:0]    win_q, win_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [N_REQ-1:0] rvalid_q, rvalid_d;
    logic [DW-1:0]    rdata_q, rdata_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic             mrd_q, mrd_d;
    logic             mwr_q, mwr_d;
    logic [N_REQ-1:0] arb_gnt;
    logic [PW-1:0]    arb_idx;

    rr_arbiter #(.N_REQ(N_REQ), .PW(PW)) u_rr (
        .req_i (bus.req),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx)
    );

    // Next state and registered outputs; strobes and pulses default low, datapath holds.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        win_d    = win_q;
        gnt_d    = '0;
        rvalid_d = '0;
        rdata_d  = rdata_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        mrd_d    = 1'b0;
        mwr_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    win_d   = arb_idx;
                    gnt_d   = arb_gnt;
                    addr_d  = bus.addr[int'(arb_idx)*AW +: AW];
                    wdata_d = bus.wdata[int'(arb_idx)*DW +: DW];
                    mwr_d   = bus.we[arb_idx];
                    mrd_d   = ~bus.we[arb_idx];
                    ptr_d   = PW'((int'(arb_idx) + 1) % N_REQ);
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                // The memory acts on the edge closing this cycle; only reads need a capture slot.
                state_d = mwr_q ? IDLE : RD_CAPTURE;
`ifdef MEM_ARBITER_LOCK_EN
                // A held lock pins the pointer on the winner so it re-wins the next arbitration.
                if (bus.lock[win_q]) begin
                    ptr_d = win_q;
                end
`endif
            end
            RD_CAPTURE: begin
                rdata_d         = bus.mem_rdata;
                rvalid_d[win_q] = 1'b1;
                state_d         = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset discards any in-flight read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            win_q    <= '0;
            gnt_q    <= '0;
            rvalid_q <= '0;
            rdata_q  <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            mrd_q    <= 1'b0;
            mwr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            win_q    <= win_d;
            gnt_q    <= gnt_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            mrd_q    <= mrd_d;
            mwr_q    <= mwr_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.rvalid    = rvalid_q;
    assign bus.rdata     = rdata_q;
    assign bus.mem_mrd   = mrd_q;
    assign bus.mem_mwr   = mwr_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: bench for mem_arbiter with a behavioural single-port memory.
// Directed table, multi-cycle corner sequences, then randomized traffic against a transaction model.
// Define MEM_ARBITER_LOCK_EN to also exercise the lock sequence.
module tb_mem_arbiter;
    localparam int NR = 2;
    localparam int AW = 5;
    localparam int DW = 16;

    typedef struct {
        int            idx;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
    } vec_t;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_fail = 0;

    logic [DW-1:0] mem [2**AW];

    // transaction model state
    logic [DW-1:0] mdl   [2**AW];
    bit            known [2**AW];
    logic [NR-1:0] e_gnt [int];
    logic [NR-1:0] e_rv  [int];
    logic [DW-1:0] e_rd  [int];
    bit            pend  [NR];
    bit            p_we  [NR];
    logic [AW-1:0] p_addr[NR];
    logic [DW-1:0] p_wd  [NR];
    int            ptr, free_at, c, w, ng, nrv, last_g;
    logic [NR-1:0] eg, erv, rq;
    vec_t          tbl [10];
    logic [DW-1:0] bdata [3];

    mem_arbiter_if #(.N_REQ(NR), .AW(AW), .DW(DW)) bus ();

    mem_arbiter #(.N_REQ(NR), .AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Single-port memory: write on MWR edge, read data appears the cycle after MRD is sampled.
    always @(posedge clk) begin
        if (bus.mem_mwr) mem[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_mrd) bus.mem_rdata <= mem[bus.mem_addr];
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic clear_inputs();
        bus.req   = '0;
        bus.we    = '0;
        bus.addr  = '0;
        bus.wdata = '0;
`ifdef MEM_ARBITER_LOCK_EN
        bus.lock  = '0;
`endif
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"},    32'(bus.gnt),       0);
        check({tag, "_rvalid"}, 32'(bus.rvalid),    0);
        check({tag, "_mrd"},    32'(bus.mem_mrd),   0);
        check({tag, "_mwr"},    32'(bus.mem_mwr),   0);
        check({tag, "_rdata"},  32'(bus.rdata),     0);
        check({tag, "_maddr"},  32'(bus.mem_addr),  0);
        check({tag, "_mwdata"}, 32'(bus.mem_wdata), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One isolated transaction from an idle arbiter; called at a negedge.
    task automatic run_txn(input int i, input bit we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [DW-1:0] exp);
        bus.req[i]            = 1'b1;
        bus.we[i]             = we;
        bus.addr[i*AW +: AW]  = a;
        bus.wdata[i*DW +: DW] = d;
        @(negedge clk);
        check("txn_gnt",   32'(bus.gnt), 32'(1 << i));
        check("txn_mwr",   32'(bus.mem_mwr), 32'(we));
        check("txn_mrd",   32'(bus.mem_mrd), 32'(!we));
        check("txn_maddr", 32'(bus.mem_addr), 32'(a));
        if (we) check("txn_mwdata", 32'(bus.mem_wdata), 32'(d));
        bus.req[i] = 1'b0;
        @(negedge clk);
        check("txn_gnt_clear", 32'(bus.gnt), 0);
        check("txn_strobe_clear", 32'({bus.mem_mrd, bus.mem_mwr}), 0);
        check("txn_no_early_rvalid", 32'(bus.rvalid), 0);
        if (!we) begin
            @(negedge clk);
            check("txn_rvalid", 32'(bus.rvalid), 32'(1 << i));
            check("txn_rdata",  32'(bus.rdata), 32'(exp));
            @(negedge clk);
            check("txn_rvalid_pulse", 32'(bus.rvalid), 0);
            check("txn_rdata_hold",   32'(bus.rdata), 32'(exp));
        end
    endtask

    initial begin
        tbl[0] = '{0, 1'b1, 5'd5,  16'hA5A5, 16'h0000};
        tbl[1] = '{0, 1'b0, 5'd5,  16'h0000, 16'hA5A5};
        tbl[2] = '{0, 1'b1, 5'd31, 16'hFFFF, 16'h0000};
        tbl[3] = '{0, 1'b1, 5'd0,  16'h0001, 16'h0000};
        tbl[4] = '{0, 1'b0, 5'd31, 16'h0000, 16'hFFFF};
        tbl[5] = '{0, 1'b0, 5'd0,  16'h0000, 16'h0001};
        tbl[6] = '{1, 1'b1, 5'd2,  16'h1234, 16'h0000};
        tbl[7] = '{1, 1'b1, 5'd3,  16'hBEEF, 16'h0000};
        tbl[8] = '{0, 1'b1, 5'd4,  16'h0F0F, 16'h0000};
        tbl[9] = '{1, 1'b0, 5'd2,  16'h0000, 16'h1234};
        bdata[0] = 16'h1234;
        bdata[1] = 16'hBEEF;
        bdata[2] = 16'h0F0F;

        // reset state
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // directed table: write/read, address wrap, both requesters
        for (int v = 0; v < 10; v++)
            run_txn(tbl[v].idx, tbl[v].we, tbl[v].addr, tbl[v].wdata, tbl[v].rdata);

        // back-to-back reads from requester 0, re-requested right after each grant
        bus.req[0] = 1'b1; bus.we[0] = 1'b0; bus.addr[0 +: AW] = 5'd2;
        ng = 0; nrv = 0; last_g = 0;
        for (int t = 0; t < 30 && nrv < 3; t++) begin
            @(negedge clk);
            check("b2b_excl", 32'(bus.mem_mrd & bus.mem_mwr), 0);
            if (bus.gnt != 0) begin
                check("b2b_gnt", 32'(bus.gnt), 1);
                if (ng > 0) check("b2b_spacing", cyc - last_g, 3);
                last_g = cyc;
                ng++;
                if (ng < 3) bus.addr[0 +: AW] = AW'(2 + ng);
                else        bus.req[0] = 1'b0;
            end
            if (bus.rvalid != 0) begin
                check("b2b_rvalid", 32'(bus.rvalid), 1);
                check("b2b_rdata", 32'(bus.rdata), 32'(bdata[nrv]));
                nrv++;
            end
        end
        check("b2b_grants", ng, 3);
        check("b2b_rvalids", nrv, 3);

        // reset during RD_CAPTURE; the grant to 0 left the pointer at 1 beforehand
        bus.req[0] = 1'b1; bus.we[0] = 1'b0; bus.addr[0 +: AW] = 5'd5;
        @(negedge clk);
        check("rstrd_gnt", 32'(bus.gnt), 1);
        bus.req[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rstrd");
        @(negedge clk);
        check("rstrd_no_rvalid0", 32'(bus.rvalid), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rstrd_no_rvalid1", 32'(bus.rvalid), 0);
        bus.req = 2'b11; bus.we = 2'b11;
        bus.addr = {5'd10, 5'd9}; bus.wdata = {16'h2222, 16'h1111};
        @(negedge clk);
        check("rstrd_ptr_zero", 32'(bus.gnt), 1);
        bus.req[0] = 1'b0;
        @(negedge clk);
        check("rstrd_gap", 32'(bus.gnt), 0);
        @(negedge clk);
        check("rstrd_req1", 32'(bus.gnt), 2);
        check("rstrd_req1_addr", 32'(bus.mem_addr), 10);
        bus.req = '0;
        @(negedge clk);

        // contention: 0 writes addr 1, 1 reads addr 1, both held
        do_reset();
        bus.req = 2'b11; bus.we = 2'b01;
        bus.addr = {5'd1, 5'd1}; bus.wdata = {16'h0000, 16'h00C3};
        ng = 0; nrv = 0;
        for (int t = 0; t < 40 && ng < 6; t++) begin
            @(negedge clk);
            check("cont_excl", 32'(bus.mem_mrd & bus.mem_mwr), 0);
            if (bus.gnt != 0) begin
                check("cont_order", 32'(bus.gnt), 32'(1 << (ng % 2)));
                ng++;
            end
            if (bus.rvalid != 0) begin
                check("cont_rvalid", 32'(bus.rvalid), 2);
                check("cont_rdata", 32'(bus.rdata), 32'h00C3);
                nrv++;
            end
        end
        check("cont_grants", ng, 6);
        bus.req = '0;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            if (bus.rvalid != 0) begin
                check("cont_rdata_last", 32'(bus.rdata), 32'h00C3);
                nrv++;
            end
        end
        check("cont_rvalids", nrv, 3);

`ifdef MEM_ARBITER_LOCK_EN
        // lock: requester 0 keeps winning while locked, then 1 gets the next grant
        do_reset();
        bus.req = 2'b11; bus.we = 2'b11;
        bus.addr = {5'd12, 5'd11}; bus.wdata = {16'h4444, 16'h3333};
        bus.lock = 2'b01;
        ng = 0;
        for (int t = 0; t < 30 && ng < 4; t++) begin
            @(negedge clk);
            if (bus.gnt != 0) begin
                check("lock_order", 32'(bus.gnt), (ng < 3) ? 1 : 2);
                ng++;
                if (ng == 3) bus.lock[0] = 1'b0;
            end
        end
        check("lock_grants", ng, 4);
        clear_inputs();
`endif

        // randomized traffic against the transaction-level model
        do_reset();
        ptr = 0;
        free_at = 0;
        for (int i = 0; i < NR; i++) begin
            pend[i] = 1'b0; p_we[i] = 1'b0; p_addr[i] = '0; p_wd[i] = '0;
        end
        for (int t = 0; t < 700; t++) begin
            @(negedge clk);
            c   = cyc;
            eg  = e_gnt.exists(c) ? e_gnt[c] : '0;
            erv = e_rv.exists(c)  ? e_rv[c]  : '0;
            check("rnd_gnt",    32'(bus.gnt),    32'(eg));
            check("rnd_rvalid", 32'(bus.rvalid), 32'(erv));
            if (erv != 0 && e_rd.exists(c)) check("rnd_rdata", 32'(bus.rdata), 32'(e_rd[c]));
            check("rnd_excl", 32'(bus.mem_mrd & bus.mem_mwr), 0);
            for (int i = 0; i < NR; i++) begin
                if (bus.gnt[i]) pend[i] = 1'b0;
                else if (pend[i] && $urandom_range(0, 39) == 0) pend[i] = 1'b0;
                if (!pend[i] && t < 650 && $urandom_range(0, 2) != 0) begin
                    pend[i]   = 1'b1;
                    p_we[i]   = 1'($urandom_range(0, 1));
                    p_addr[i] = AW'($urandom_range(0, 2**AW - 1));
                    p_wd[i]   = DW'($urandom);
                end
                bus.req[i]            = pend[i];
                bus.we[i]             = p_we[i];
                bus.addr[i*AW +: AW]  = p_addr[i];
                bus.wdata[i*DW +: DW] = p_wd[i];
                rq[i]                 = pend[i];
            end
            // arbitration decision for the coming edge, if the arbiter is free then
            if (c + 1 >= free_at && rq != 0) begin
                w = -1;
                for (int k = 0; k < NR; k++)
                    if (w < 0 && rq[(ptr + k) % NR]) w = (ptr + k) % NR;
                ptr = (w + 1) % NR;
                e_gnt[c + 1] = NR'(1 << w);
                if (p_we[w]) begin
                    mdl[p_addr[w]]   = p_wd[w];
                    known[p_addr[w]] = 1'b1;
                    free_at = c + 3;
                end else begin
                    e_rv[c + 3] = NR'(1 << w);
                    if (known[p_addr[w]]) e_rd[c + 3] = mdl[p_addr[w]];
                    free_at = c + 4;
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
